// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle ALU.
package alu_pkg;

    // Opcode width as carried on alu_ctrl; wider control buses map codes >= 14 to illegal.
    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13,
        OP_ILL14 = 4'd14,
        OP_ILL15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Ops that run on the shared iterative engine.
    function automatic logic is_multicycle(input alu_op_e op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // Ops that use the divide half of the engine.
    function automatic logic is_div(input alu_op_e op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared iterative engine: unsigned shift-add multiply and restoring divide,
// one bit per cycle over a 2*XLEN working register.
//   mul: work = {product_hi, product_lo}   after XLEN steps
//   div: work = {remainder,  quotient}     after XLEN steps
module alu_mc_iter
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            op_div,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] hi
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] work;
    logic [2*XLEN-1:0] work_next;
    logic [XLEN-1:0]   opnd;
    logic [CW-1:0]     count;
    logic              mode_div;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;

    // One iteration step of whichever algorithm is loaded.
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        work_next = work;
        mul_sum   = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, opnd};
        // Partial remainder shifted left by one needs XLEN+1 bits; the top bit of the difference is the borrow.
        div_trial = work[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        if (mode_div) begin
            if (!div_trial[XLEN]) begin
                work_next = {div_trial[XLEN-1:0], work[XLEN-2:0], 1'b1};
            end else begin
                work_next = {work[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (work[0]) begin
                work_next = {mul_sum, work[XLEN-1:1]};
            end else begin
                work_next = {1'b0, work[2*XLEN-1:1]};
            end
        end
    end

    // Load operands on start, then step once per cycle until the counter drains.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work     <= '0;
            opnd     <= '0;
            count    <= '0;
            mode_div <= 1'b0;
        end else if (start) begin
            work     <= {{XLEN{1'b0}}, op_a};
            opnd     <= op_b;
            count    <= CW'(XLEN);
            mode_div <= op_div;
        end else if (count != '0) begin
            work  <= work_next;
            count <= count - 1'b1;
        end
    end

    // High during the cycle whose closing edge performs the final step.
    assign done = (count == CW'(1));
    assign lo   = work[XLEN-1:0];
    assign hi   = work[2*XLEN-1:XLEN];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake. Single-cycle ops register their
// result on the accepting edge; MUL/MULHU/DIVU/REMU run on alu_mc_iter and
// present their result XLEN+1 edges after acceptance.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              zero,
    output logic              illegal,
    output logic              busy
);

    localparam int SHW = $clog2(XLEN);

    state_e          state;
    alu_op_e         op_in;
    alu_op_e         op_q;
    logic            legal_in;
    logic            div_by_zero;
    logic            accept;
    logic            start_iter;
    logic            rdy_en;
    logic            iter_done;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] single_res;
    logic [XLEN-1:0] quick_res;
    logic [XLEN-1:0] iter_res;
    logic [XLEN-1:0] iter_lo;
    logic [XLEN-1:0] iter_hi;

    assign op_in       = alu_op_e'(alu_ctrl[OP_W-1:0]);
    assign legal_in    = (alu_ctrl < CTRL_W'(14));
    assign shamt       = b[SHW-1:0];
    assign div_by_zero = legal_in && is_div(op_in) && (b == '0);
    assign accept      = in_valid && in_ready;
    assign start_iter  = accept && legal_in && is_multicycle(op_in) && !div_by_zero;

    // in_ready is held low for the first cycle out of reset, then follows the FSM and output slot.
    assign in_ready = rdy_en && (state == IDLE) && (!out_valid || out_ready);
    assign busy     = (state != IDLE);

    // Single-cycle datapath on the live request operands.
    always_comb begin
        single_res = '0;
        case (op_in)
            OP_ADD:  single_res = a + b;
            OP_SUB:  single_res = a - b;
            OP_AND:  single_res = a & b;
            OP_OR:   single_res = a | b;
            OP_XOR:  single_res = a ^ b;
            OP_SLT:  single_res = XLEN'($signed(a) < $signed(b));
            OP_SLTU: single_res = XLEN'(a < b);
            OP_SLL:  single_res = a << shamt;
            OP_SRL:  single_res = a >> shamt;
            OP_SRA:  single_res = $unsigned($signed(a) >>> shamt);
            default: single_res = '0;
        endcase
    end

    // Result for everything completing on the accept edge: single-cycle, illegal, divide by zero.
    always_comb begin
        quick_res = single_res;
        if (!legal_in) begin
            quick_res = '0;
        end else if (div_by_zero) begin
            quick_res = (op_in == OP_DIVU) ? '1 : a;
        end
    end

    // Pick the engine half that holds the requested answer.
    always_comb begin
        iter_res = iter_hi;
        if ((op_q == OP_MUL) || (op_q == OP_DIVU)) begin
            iter_res = iter_lo;
        end
    end

    alu_mc_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_iter),
        .op_div (is_div(op_in)),
        .op_a   (a),
        .op_b   (b),
        .done   (iter_done),
        .lo     (iter_lo),
        .hi     (iter_hi)
    );

    // Control FSM and output register; a result stays put until out_valid && out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_ADD;
            rdy_en    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_iter) begin
                        op_q  <= op_in;
                        state <= is_div(op_in) ? DIV : MUL;
                    end else if (accept) begin
                        out_valid <= 1'b1;
                        result    <= quick_res;
                        zero      <= (quick_res == '0);
                        illegal   <= !legal_in;
                    end
                end
                MUL, DIV: begin
                    if (iter_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    out_valid <= 1'b1;
                    result    <= iter_res;
                    zero      <= (iter_res == '0);
                    illegal   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (XLEN=32): directed vectors, randomized ops
// against an arithmetic reference model, back-to-back, backpressure and reset abort.
module tb_alu_mc;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 4;
    localparam int MULTI_LAT = XLEN + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] alu_ctrl = '0;
    logic [XLEN-1:0]   a = '0;
    logic [XLEN-1:0]   b = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [XLEN-1:0]   result;
    logic              zero;
    logic              illegal;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mc #(
        .XLEN   (XLEN),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    // Reference model: expected result, illegal flag and the number of clock
    // edges after the accepting edge before out_valid appears (0 = on that edge).
    function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic il, output int lat);
        logic [63:0] p;
        p   = 64'(x) * 64'(y);
        r   = '0;
        il  = 1'b0;
        lat = 0;
        case (op)
            4'd0:  r = x + y;
            4'd1:  r = x - y;
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd6:  r = (x < y) ? 32'd1 : 32'd0;
            4'd7:  r = x << y[4:0];
            4'd8:  r = x >> y[4:0];
            4'd9:  r = $unsigned($signed(x) >>> y[4:0]);
            4'd10: begin r = p[31:0];  lat = MULTI_LAT; end
            4'd11: begin r = p[63:32]; lat = MULTI_LAT; end
            4'd12: if (y == 0) r = 32'hFFFF_FFFF; else begin r = x / y; lat = MULTI_LAT; end
            4'd13: if (y == 0) r = x;             else begin r = x % y; lat = MULTI_LAT; end
            default: il = 1'b1;
        endcase
    endfunction

    // Issue one op (out_ready assumed high) and wait for its result. Inputs are
    // scrambled right after acceptance so any re-sampling corrupts the answer.
    // bad counts cycles where busy/in_ready were wrong while the op was in flight.
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic z, output logic il,
                          output int lat, output int bad);
        int guard;
        guard    = 0;
        bad      = 0;
        lat      = 0;
        alu_ctrl = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout op=%0d in_ready=%b expected 1", op, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_ctrl = CTRL_W'($urandom);
        a        = $urandom;
        b        = $urandom;
        while (!out_valid && lat < 200) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_timeout op=%0d out_valid=%b expected 1", op, out_valid);
        end
        r  = result;
        z  = zero;
        il = illegal;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, zero, illegal, busy, in_ready} !== 5'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_values {ov,z,il,busy,rdy}=%b result=%h expected 00000 0",
                     {out_valid, zero, illegal, busy, in_ready}, result);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_release in_ready=%b expected 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_one_cycle_later in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_cycle();
        logic [3:0]  t_op [10] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd9, 4'd8, 4'd2, 4'd3, 4'd4, 4'd7};
        logic [31:0] t_a  [10] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                   32'h8000_0000, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'd1};
        logic [31:0] t_b  [10] = '{32'd1, 32'd7, 32'd1, 32'd1, 32'h1F,
                                   32'h1F, 32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'hFFFF_FFFF};
        logic [31:0] t_r  [10] = '{32'h0, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'hFFFF_FFFF,
                                   32'd1, 32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'h8000_0000};
        logic [31:0] r;
        logic z, il;
        int lat, bad;
        for (int i = 0; i < 10; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], r, z, il, lat, bad);
            checks++;
            if (r !== t_r[i] || z !== (t_r[i] == 0) || il !== 1'b0) begin
                errors++;
                $display("FAIL single[%0d] op=%0d result=%h zero=%b illegal=%b expected %h %b 0",
                         i, t_op[i], r, z, il, t_r[i], (t_r[i] == 0));
            end
            checks++;
            if (lat !== 0) begin
                errors++;
                $display("FAIL single_latency[%0d] extra_edges=%0d expected 0", i, lat);
            end
        end
    endtask

    task automatic test_multicycle();
        logic [3:0]  t_op  [8] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd12, 4'd13, 4'd11, 4'd12};
        logic [31:0] t_a   [8] = '{32'h10000, 32'h10000, 32'd100, 32'd100, 32'h1234, 32'h1234,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_b   [8] = '{32'h10000, 32'h10000, 32'd7, 32'd7, 32'd0, 32'd0,
                                   32'hFFFF_FFFF, 32'd1};
        logic [31:0] t_r   [8] = '{32'd0, 32'd1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234,
                                   32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int          t_lat [8] = '{MULTI_LAT, MULTI_LAT, MULTI_LAT, MULTI_LAT, 0, 0, MULTI_LAT, MULTI_LAT};
        logic [31:0] r;
        logic z, il;
        int lat, bad;
        for (int i = 0; i < 8; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], r, z, il, lat, bad);
            checks++;
            if (r !== t_r[i] || z !== (t_r[i] == 0) || il !== 1'b0) begin
                errors++;
                $display("FAIL multi[%0d] op=%0d result=%h zero=%b illegal=%b expected %h %b 0",
                         i, t_op[i], r, z, il, t_r[i], (t_r[i] == 0));
            end
            checks++;
            if (lat !== t_lat[i] || bad !== 0) begin
                errors++;
                $display("FAIL multi_timing[%0d] edges=%0d busy_ready_bad=%0d expected %0d 0",
                         i, lat, bad, t_lat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] x, y, r, er;
        logic z, il, eil;
        int lat, elat, bad;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 40);
                default: y = $urandom;
            endcase
            model(op, x, y, er, eil, elat);
            run_op(op, x, y, r, z, il, lat, bad);
            checks++;
            if (r !== er || z !== (er == 0) || il !== eil || lat !== elat || bad !== 0) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h result=%h zero=%b illegal=%b edges=%0d bad=%0d expected %h %b %b %0d 0",
                         i, op, x, y, r, z, il, lat, bad, er, (er == 0), eil, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op;
        logic [31:0] er;
        logic eil;
        int elat;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            op = 4'($urandom_range(0, 11));
            if (op >= 4'd10) op = op + 4'd4;
            alu_ctrl = op;
            a        = $urandom;
            b        = $urandom;
            in_valid = 1'b1;
            model(op, a, b, er, eil, elat);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d] in_ready=%b expected 1", i, in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== er || illegal !== eil || zero !== (er == 0)) begin
                errors++;
                $display("FAIL b2b[%0d] op=%0d out_valid=%b result=%h illegal=%b zero=%b expected 1 %h %b %b",
                         i, op, out_valid, result, illegal, zero, er, eil, (er == 0));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic z, il;
        int lat, bad;
        @(posedge clk); #1;
        out_ready = 1'b0;
        alu_ctrl  = 4'd0;
        a         = 32'd3;
        b         = 32'd4;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_initial in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 32'd100;
        b        = 32'd200;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] out_valid=%b result=%h in_ready=%b expected 1 00000007 0",
                         i, out_valid, result, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        alu_ctrl  = 4'd1;
        a         = 32'd5;
        b         = 32'd7;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL bp_next_op out_valid=%b result=%h expected 1 fffffffe", out_valid, result);
        end
        run_op(4'd15, 32'hDEAD_BEEF, 32'h1234_5678, r, z, il, lat, bad);
        checks++;
        if (r !== 32'd0 || z !== 1'b1 || il !== 1'b1 || lat !== 0) begin
            errors++;
            $display("FAIL illegal_op result=%h zero=%b illegal=%b edges=%0d expected 00000000 1 1 0",
                     r, z, il, lat);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        logic z, il;
        int lat, bad;
        run_op(4'd0, 32'd3, 32'd4, r, z, il, lat, bad);
        alu_ctrl = 4'd12;
        a        = 32'd1000;
        b        = 32'd3;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_accept in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_async out_valid=%b busy=%b result=%h in_ready=%b expected 0 0 0 0",
                     out_valid, busy, result, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_ghost out_valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        run_op(4'd0, 32'd1, 32'd1, r, z, il, lat, bad);
        checks++;
        if (r !== 32'd2 || z !== 1'b0 || il !== 1'b0 || lat !== 0) begin
            errors++;
            $display("FAIL abort_recover result=%h zero=%b illegal=%b edges=%0d expected 00000002 0 0 0",
                     r, z, il, lat);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_multicycle();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
